// File: rtl/ftd_pkg.sv
// ftd_pkg: shared constants and helpers for the fine-time decoder.
//   FINE_W / WORD_W  - fine bin width and sampler word width
//   FINE_LSB, COARSE_LSB, err_bit() - timestamp field placement
//   prio_enc()       - index of the lowest set bit of a sampler word
//   popcnt()         - number of set bits in a sampler word
package ftd_pkg;

    localparam int FINE_W     = 5;
    localparam int WORD_W     = 32;
    localparam int FINE_LSB   = 0;
    localparam int COARSE_LSB = FINE_W;

    // The error flag sits directly above the coarse field.
    function automatic int err_bit(input int coarse_w);
        return coarse_w + FINE_W;
    endfunction

    // Lowest set bit wins; the loop runs high-to-low so the last hit is the lowest.
    function automatic logic [FINE_W-1:0] prio_enc(input logic [WORD_W-1:0] w);
        logic [FINE_W-1:0] idx;
        idx = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (w[i]) idx = FINE_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [FINE_W:0] popcnt(input logic [WORD_W-1:0] w);
        logic [FINE_W:0] n;
        n = '0;
        for (int i = 0; i < WORD_W; i++) begin
            n = n + {{FINE_W{1'b0}}, w[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ftd_ts_fifo.sv
// ftd_ts_fifo: synchronous timestamp FIFO.
//   clk, reset_n      - clock, async active-low reset (pointers cleared, contents lost)
//   push_i, wdata_i   - write request / data; accepted when not full or popping
//   pop_i             - consumer ready; pops only when not empty
//   rdata_o           - head entry, or last popped entry while empty
//   empty_o, full_o   - occupancy flags
//   level_o           - current occupancy
module ftd_ts_fifo #(
    parameter int W     = 22,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic [W-1:0]  hold_q;
    logic          do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot on the same edge, so a full FIFO can still take a push.
    assign do_push = push_i & (~full_o | do_pop);
    assign level_o = wptr_q - rptr_q;

    // While empty the output shows the last popped entry (zero after reset).
    assign rdata_o = empty_o ? hold_q : mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            hold_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
                hold_q <= mem[rptr_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/fine_time_decoder.sv
// fine_time_decoder: hit detection, fine-bin encoding and timestamp buffering
// for the multi-phase sampler word, all in the sampler clk[4] domain.
//   clk, reset_n  - clock, async active-low reset
//   enable        - hit acceptance enable
//   coarse_clr    - synchronous clear of the coarse counter
//   fine_word     - sampler edge-pattern word, new every cycle
//   ts_data       - {err, coarse, fine} at the FIFO head
//   ts_valid      - FIFO head valid
//   ts_ready      - consumer pops the head when ts_valid & ts_ready
//   fifo_level    - FIFO occupancy
//   drop_count    - saturating count of hits lost to a full FIFO
module fine_time_decoder
    import ftd_pkg::*;
#(
    parameter int COARSE_W   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DEAD_CYC   = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          coarse_clr,
    input  logic [WORD_W-1:0]             fine_word,
    output logic [COARSE_W+FINE_W:0]      ts_data,
    output logic                          ts_valid,
    input  logic                          ts_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_count
);

    localparam int TS_W    = COARSE_W + FINE_W + 1;
    localparam int ERR_BIT = err_bit(COARSE_W);
    localparam int DW      = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic                hit_d;
    logic [1:0]          vld_pipe_q;   // [0]: stage-1 hit, [1]: stage-2 timestamp ready
    logic [WORD_W-1:0]   s1_word_q;
    logic [COARSE_W-1:0] s1_coarse_q;
    logic [TS_W-1:0]     s2_ts_q, s2_ts_d;
    logic [15:0]         drop_q;
    logic                fifo_empty, fifo_full;

    always_comb begin
        coarse_d = coarse_clr ? '0 : coarse_q + COARSE_W'(1);
        hit_d    = (fine_word != '0) && enable && (dead_q == '0);
        // Dead time counts down regardless of enable so a disabled window still expires.
        if (hit_d)               dead_d = DW'(DEAD_CYC);
        else if (dead_q != '0)   dead_d = dead_q - DW'(1);
        else                     dead_d = '0;
        s2_ts_d                             = '0;
        s2_ts_d[ERR_BIT]                    = (popcnt(s1_word_q) > (FINE_W+1)'(1));
        s2_ts_d[COARSE_LSB +: COARSE_W]     = s1_coarse_q;
        s2_ts_d[FINE_LSB +: FINE_W]         = prio_enc(s1_word_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coarse_q    <= '0;
            dead_q      <= '0;
            vld_pipe_q  <= '0;
            s1_word_q   <= '0;
            s1_coarse_q <= '0;
            s2_ts_q     <= '0;
            drop_q      <= '0;
        end else begin
            coarse_q    <= coarse_d;
            dead_q      <= dead_d;
            vld_pipe_q  <= {vld_pipe_q[0], hit_d};
            s1_word_q   <= fine_word;
            s1_coarse_q <= coarse_q;
            s2_ts_q     <= s2_ts_d;
            // When full the head is valid, so ts_ready alone decides whether a slot frees up.
            if (vld_pipe_q[1] && fifo_full && !ts_ready && (drop_q != 16'hFFFF))
                drop_q <= drop_q + 16'd1;
        end
    end

    ftd_ts_fifo #(
        .W     (TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (vld_pipe_q[1]),
        .wdata_i (s2_ts_q),
        .pop_i   (ts_ready),
        .rdata_o (ts_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    assign ts_valid   = ~fifo_empty;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_fine_time_decoder.sv
module tb_fine_time_decoder;

    logic        clk = 1'b0;
    logic        reset_n, enable, enable4, coarse_clr, ts_ready, ts_ready4;
    logic [31:0] fine_word;

    logic [21:0] ts_data;
    logic        ts_valid;
    logic [4:0]  fifo_level;
    logic [15:0] drop_count;

    logic [9:0]  ts_data4;
    logic        ts_valid4;
    logic [4:0]  fifo_level4;
    logic [15:0] drop_count4;

    int checks   = 0;
    int failures = 0;

    logic [21:0] q16[$];
    logic [9:0]  q4[$];
    logic [21:0] exp16;
    logic [9:0]  exp4;
    logic [15:0] tb_c = '0;   // coarse value the next edge will stamp

    always #5 clk = ~clk;

    fine_time_decoder #(.COARSE_W(16), .FIFO_DEPTH(16), .DEAD_CYC(2)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .coarse_clr(coarse_clr),
        .fine_word(fine_word), .ts_data(ts_data), .ts_valid(ts_valid),
        .ts_ready(ts_ready), .fifo_level(fifo_level), .drop_count(drop_count)
    );

    fine_time_decoder #(.COARSE_W(4), .FIFO_DEPTH(16), .DEAD_CYC(0)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable4), .coarse_clr(coarse_clr),
        .fine_word(fine_word), .ts_data(ts_data4), .ts_valid(ts_valid4),
        .ts_ready(ts_ready4), .fifo_level(fifo_level4), .drop_count(drop_count4)
    );

    task automatic tick;
        @(posedge clk);
        if (!reset_n)        tb_c = '0;
        else if (coarse_clr) tb_c = '0;
        else                 tb_c = tb_c + 16'd1;
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare the head whenever the DUT hands one over.
    always @(negedge clk) begin
        if (reset_n && ts_valid && ts_ready) begin
            checks++;
            if (q16.size() == 0) begin
                failures++;
                $display("FAIL ts16_unexpected got=%0h exp=none", ts_data);
            end else begin
                exp16 = q16.pop_front();
                if (ts_data !== exp16) begin
                    failures++;
                    $display("FAIL ts16_data got=%0h exp=%0h", ts_data, exp16);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && ts_valid4 && ts_ready4) begin
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL ts4_unexpected got=%0h exp=none", ts_data4);
            end else begin
                exp4 = q4.pop_front();
                if (ts_data4 !== exp4) begin
                    failures++;
                    $display("FAIL ts4_data got=%0h exp=%0h", ts_data4, exp4);
                end
            end
        end
    end

    // Directed words: {word, fine, err}
    logic [31:0] vw [4];
    logic [4:0]  vf [4];
    logic        ve [4];

    initial begin
        vw[0] = 32'h0000_0B00; vf[0] = 5'd8;  ve[0] = 1'b1;
        vw[1] = 32'h8000_0000; vf[1] = 5'd31; ve[1] = 1'b0;
        vw[2] = 32'hFFFF_FFFF; vf[2] = 5'd0;  ve[2] = 1'b1;
        vw[3] = 32'h0000_0001; vf[3] = 5'd0;  ve[3] = 1'b0;

        reset_n = 1'b0; enable = 1'b0; enable4 = 1'b0; coarse_clr = 1'b0;
        ts_ready = 1'b1; ts_ready4 = 1'b1; fine_word = '0;
        tick;
        chk("rst_valid", ts_valid, 0);
        chk("rst_data", ts_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_count, 0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Single clean hit: latency and pop
        ts_ready = 1'b0;
        coarse_clr = 1'b1; tick; coarse_clr = 1'b0;
        repeat (5) tick;
        fine_word = 32'h0000_0100;
        q16.push_back({1'b0, 16'd5, 5'd8});
        tick;                           // edge E
        fine_word = '0;
        tick;                           // E+1
        chk("lat_e1_valid", ts_valid, 0);
        tick;                           // E+2
        chk("lat_e2_valid", ts_valid, 1);
        chk("lat_e2_level", fifo_level, 1);
        ts_ready = 1'b1;
        tick;
        chk("pop_valid", ts_valid, 0);
        chk("hold_data", ts_data, {1'b0, 16'd5, 5'd8});

        // Word table: bubble, msb, all-ones, lsb
        for (int i = 0; i < 4; i++) begin
            fine_word = vw[i];
            q16.push_back({ve[i], tb_c, vf[i]});
            tick;
            fine_word = '0;
            repeat (4) tick;
        end

        // enable low: nothing accepted
        enable = 1'b0;
        fine_word = 32'h0000_0010;
        tick;
        fine_word = '0;
        enable = 1'b1;
        repeat (4) tick;
        chk("disabled_level", fifo_level, 0);

        // Dead time: 4 consecutive hits, samples 1 and 4 kept
        for (int k = 0; k < 4; k++) begin
            fine_word = 32'h0000_0010;
            if (k == 0 || k == 3) q16.push_back({1'b0, tb_c, 5'd4});
            tick;
        end
        fine_word = '0;
        repeat (5) tick;
        chk("dead_level", fifo_level, 0);

        // Overflow: 18 hits into a stalled FIFO
        ts_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            fine_word = 32'h1 << i;
            if (i < 16) q16.push_back({1'b0, tb_c, 5'(i)});
            tick;
            fine_word = '0;
            repeat (2) tick;
        end
        tick;
        chk("ovf_level", fifo_level, 16);
        chk("ovf_drop", drop_count, 2);
        chk("ovf_head", ts_data, q16[0]);

        // Simultaneous pop and push while full
        fine_word = 32'h0000_4000;
        q16.push_back({1'b0, tb_c, 5'd14});
        tick;                           // E
        fine_word = '0;
        tick;                           // E+1
        ts_ready = 1'b1;
        tick;                           // E+2: push and pop together
        ts_ready = 1'b0;
        chk("fullpp_level", fifo_level, 16);
        chk("fullpp_drop", drop_count, 2);
        ts_ready = 1'b1;
        repeat (20) tick;
        chk("drain_level", fifo_level, 0);
        chk("drain_valid", ts_valid, 0);
        chk("drain_sb", q16.size(), 0);

        // Coarse wrap on the 4-bit instance, no dead time
        enable = 1'b0; enable4 = 1'b1;
        coarse_clr = 1'b1; tick; coarse_clr = 1'b0;
        repeat (15) tick;
        fine_word = 32'h2; q4.push_back({1'b0, 4'd15, 5'd1});
        tick;
        fine_word = '0;
        tick;
        fine_word = 32'h2; q4.push_back({1'b0, 4'd1, 5'd1});
        tick;
        fine_word = 32'h3; q4.push_back({1'b1, 4'd2, 5'd0});
        tick;
        fine_word = '0;
        repeat (5) tick;
        chk("wrap_sb", q4.size(), 0);

        // Async reset with entries queued
        enable = 1'b1; ts_ready = 1'b0; ts_ready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fine_word = 32'h80;
            tick;
            fine_word = '0;
            repeat (2) tick;
        end
        repeat (2) tick;
        chk("prerst_level", fifo_level, 3);
        chk("prerst_level4", fifo_level4, 3);
        chk("prerst_drop", drop_count, 2);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", ts_valid, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_drop", drop_count, 0);
        chk("arst_data", ts_data, 0);
        chk("arst_valid4", ts_valid4, 0);
        chk("arst_level4", fifo_level4, 0);
        tick;
        reset_n = 1'b1; ts_ready = 1'b1; ts_ready4 = 1'b1; enable4 = 1'b0;

        // Recovery hit after reset, coarse restarts from 0
        tick;
        fine_word = 32'h0040_0000;
        q16.push_back({1'b0, tb_c, 5'd22});
        tick;
        fine_word = '0;
        repeat (6) tick;
        chk("final_sb16", q16.size(), 0);
        chk("final_sb4", q4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fine_time_decoder.md
Name: fine_time_decoder

Overview:
Consumer side of the multi-phase fine-time sampler. Takes the 32-bit edge-pattern word the sampler registers on every clk[4] cycle, detects hits, and priority-encodes the edge position into a 5-bit fine bin. Each hit is stamped with a free-running coarse counter, and the {error, coarse, fine} timestamps are buffered in a FIFO for the PID/trigger readout logic. Single clock domain: the sampler's clk[4].

Parameters:
COARSE_W, 16, coarse counter width in bits.
FIFO_DEPTH, 16, timestamp FIFO entries; power of 2, at least 2.
DEAD_CYC, 2, samples ignored after an accepted hit; 0 disables dead time.

Ports:
clk  in  1  sampler clk[4] domain clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  hit acceptance enable
coarse_clr  in  1  synchronous clear of the coarse counter
fine_word  in  32  edge-pattern word from the sampler, new value every cycle
ts_data  out  COARSE_W+6  {err, coarse[COARSE_W-1:0], fine[4:0]}
ts_valid  out  1  FIFO head is valid
ts_ready  in  1  consumer accepts the head when ts_valid and ts_ready are both high
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
drop_count  out  16  saturating count of hits lost to a full FIFO

Behaviour:
- Reset (asynchronous, reset_n low):
  - ts_valid=0, ts_data=0, fifo_level=0, drop_count=0.
  - Coarse counter=0, dead-time counter=0, pipeline valids=0.
  - FIFO contents are discarded. Reset mid-operation loses all pending hits, with no partial output.
- Coarse counter:
  - Increments by 1 every clk and wraps from 2^COARSE_W-1 to 0 silently.
  - coarse_clr forces the next value to 0. It takes priority over increment.
- Stage 1 (edge E):
  - Register fine_word into s1_word.
  - Register the coarse value held before edge E into s1_coarse.
  - s1_hit = (fine_word != 0) AND enable AND (dead counter == 0).
- Dead time:
  - When s1_hit is set at edge E, the dead counter loads DEAD_CYC.
  - Otherwise it decrements to 0 each cycle, independent of enable.
  - Samples at edges E+1..E+DEAD_CYC are ignored whatever their content.
- Stage 2 (edge E+1):
  - fine = index of the lowest set bit of s1_word (0..31).
  - err = 1 when popcount(s1_word) > 1, i.e. a bubble or multi-edge word.
  - If s1_hit, write {err, s1_coarse, fine} into the FIFO.
- Latency: a hit sampled at edge E sets ts_valid after edge E+2 when the FIFO was empty. No fall-through path.
- FIFO:
  - Head is presented on ts_data while ts_valid=1. Pop occurs at a clock edge with ts_valid & ts_ready.
  - ts_data holds its last value when the FIFO is empty; only ts_valid is meaningful.
  - Full and write: drop the new hit, drop_count += 1, saturating at 16'hFFFF. Head is unchanged.
  - Full with simultaneous pop and write: both succeed, level unchanged, nothing dropped.
  - Empty with simultaneous write and ready: write succeeds, no pop. Level goes to 1.
  - fifo_level updates on the same edge as the push or pop.
- No combinational path from fine_word or ts_ready to any output.

Decomposition:
- Shared package (ftd_pkg):
  - FINE_W=5 and WORD_W=32 constants.
  - Timestamp field offsets: ERR_BIT=COARSE_W+5, coarse field [COARSE_W+4:5], fine field [4:0].
  - Priority-encode and popcount functions.
- One sub-module, ftd_ts_fifo:
  - Synchronous FIFO, width COARSE_W+6, depth FIFO_DEPTH.
  - Provides the level output and full/empty flags.
  - Drop counting stays in the parent.

Test Plan:
- Single clean hit: after coarse_clr, wait 5 cycles. Drive fine_word=32'h0000_0100 for 1 cycle, zero otherwise. Expect ts_valid 2 edges later with ts_data={0, 16'd5, 5'd8}, then pop with ts_ready=1 and ts_valid drops.
- Bubble word: fine_word=32'h0000_0B00. Expect fine=8, err=1.
- Dead time (DEAD_CYC=2): drive nonzero words on 4 consecutive edges. Expect exactly 2 timestamps, from samples 1 and 4, with coarse differing by 3.
- Overflow: ts_ready=0, 18 spaced hits. Expect fifo_level=16 and drop_count=2; the first 16 entries read back in order.
- Simultaneous pop/push at full: level stays 16 and drop_count does not increment.
- Coarse wrap and reset: with COARSE_W=4, a hit at coarse 15 and another 2 cycles later stamp coarse 15 and 1. Assert reset_n low with 3 entries queued: immediately ts_valid=0, fifo_level=0, drop_count=0.
